// File: rtl/line_fifo_640x16.sv
// Single-clock line-delay FIFO: 640 x 16-bit words, registered read port, fill count.
// Storage is a simple dual-port array with a synchronous read so it maps onto block RAM.
module line_fifo_640x16 #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned DEPTH       = 640,
    parameter int unsigned USEDW_WIDTH = 10
) (
    input  logic                   clock,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  data,
    input  logic                   wrreq,
    input  logic                   rdreq,
    input  logic                   sclr,
    output logic [DATA_WIDTH-1:0]  q,
    output logic [USEDW_WIDTH-1:0] usedw
);

    localparam int unsigned PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_WIDTH-1:0]   PTR_LAST   = PTR_WIDTH'(DEPTH - 1);
    localparam logic [USEDW_WIDTH-1:0] USEDW_FULL = USEDW_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [USEDW_WIDTH-1:0] usedw_q, usedw_d;
    logic [DATA_WIDTH-1:0]  q_q;

    logic empty;
    logic full;
    logic wr_en;
    logic rd_en;

    assign empty = (usedw_q == '0);
    assign full  = (usedw_q == USEDW_FULL);

    // A read frees a slot in the same edge, so a full FIFO still accepts a paired write.
    // sclr wins over both requests, so neither RAM nor q is touched on a clear cycle.
    assign rd_en = rdreq & ~empty & ~sclr;
    assign wr_en = wrreq & (~full | rd_en) & ~sclr;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        usedw_d  = usedw_q;
        if (sclr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            usedw_d  = '0;
        end else begin
            // Depth is not a power of two: wrap on an explicit compare.
            if (wr_en) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (rd_en) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            if (wr_en && !rd_en) begin
                usedw_d = usedw_q + 1'b1;
            end else if (rd_en && !wr_en) begin
                usedw_d = usedw_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usedw_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            usedw_q  <= usedw_d;
        end
    end

    // Memory contents survive reset; only the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= data;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else if (rd_en) begin
            q_q <= mem[rd_ptr_q];
        end
    end

    assign q     = q_q;
    assign usedw = usedw_q;

endmodule

// File: tb/tb_line_fifo_640x16.sv
// Self-checking bench for line_fifo_640x16: reference FIFO model plus an expected-q queue.
module tb_line_fifo_640x16;

  localparam int DEPTH = 640;

  logic        clock;
  logic        rst_n;
  logic [15:0] data;
  logic        wrreq;
  logic        rdreq;
  logic        sclr;
  logic [15:0] q;
  logic [9:0]  usedw;

  logic [15:0] model_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] last_q;

  int n_checks;
  int n_errors;

  line_fifo_640x16 dut (
    .clock (clock),
    .rst_n (rst_n),
    .data  (data),
    .wrreq (wrreq),
    .rdreq (rdreq),
    .sclr  (sclr),
    .q     (q),
    .usedw (usedw)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle at the falling edge, update the model, check just after the rising edge.
  task automatic cycle(input logic w, input logic [15:0] d, input logic r, input logic s);
    bit rd_acc;
    bit wr_acc;
    int cnt;
    @(negedge clock);
    wrreq = w;
    data  = d;
    rdreq = r;
    sclr  = s;
    cnt    = model_q.size();
    rd_acc = 1'b0;
    wr_acc = 1'b0;
    if (s) begin
      model_q.delete();
    end else begin
      rd_acc = r && (cnt > 0);
      wr_acc = w && ((cnt < DEPTH) || rd_acc);
      if (rd_acc) exp_q.push_back(model_q.pop_front());
      if (wr_acc) model_q.push_back(d);
    end
    @(posedge clock);
    #1;
    if (rd_acc) begin
      if (exp_q.size() == 0) begin
        check_val("exp_q_underflow", 32'd1, 32'd0);
      end else begin
        last_q = exp_q.pop_front();
      end
    end
    check_val("q", 32'(q), 32'(last_q));
    check_val("usedw", 32'(usedw), 32'(model_q.size()));
  endtask

  task automatic idle_inputs();
    @(negedge clock);
    wrreq = 1'b0;
    rdreq = 1'b0;
    sclr  = 1'b0;
    data  = '0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    last_q   = '0;
    rst_n    = 1'b0;
    wrreq    = 1'b0;
    rdreq    = 1'b0;
    sclr     = 1'b0;
    data     = '0;
    repeat (3) @(posedge clock);
    #1;
    check_val("reset_usedw", 32'(usedw), 32'd0);
    check_val("reset_q", 32'(q), 32'd0);
    @(negedge clock);
    rst_n = 1'b1;

    // Asynchronous reset mid-stream with q holding a non-zero word
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_val("pre_reset_q", 32'(q), 32'h0101);
    @(negedge clock);
    wrreq = 1'b1;
    data  = 16'h7777;
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_reset_usedw", 32'(usedw), 32'd0);
    check_val("async_reset_q", 32'(q), 32'd0);
    model_q.delete();
    exp_q.delete();
    last_q = '0;
    idle_inputs();
    rst_n = 1'b1;
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_val("rd_empty_after_reset_q", 32'(q), 32'd0);

    // Ordered fill to full, one dropped write, then full drain
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 16'(i), 1'b0, 1'b0);
    check_val("full_usedw", 32'(usedw), 32'd640);
    cycle(1'b1, 16'hFFFF, 1'b0, 1'b0);
    check_val("drop_usedw", 32'(usedw), 32'd640);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      check_val("drain_q", 32'(q), 32'(i));
    end
    check_val("drained_usedw", 32'(usedw), 32'd0);

    // Line delay: continuous ramp, reads start once a full line is stored
    for (int n = 0; n < DEPTH + 300; n++) begin
      cycle(1'b1, 16'(1000 + n), (n >= DEPTH), 1'b0);
      if (n >= DEPTH) begin
        check_val("delay_q", 32'(q), 32'(1000 + n - DEPTH));
        check_val("delay_usedw", 32'(usedw), 32'd640);
      end
    end
    cycle(1'b0, '0, 1'b0, 1'b1);
    check_val("sclr_full_usedw", 32'(usedw), 32'd0);

    // Empty corner: paired read/write on empty ignores the read
    cycle(1'b1, 16'hABCD, 1'b1, 1'b0);
    check_val("empty_rw_usedw", 32'(usedw), 32'd1);
    check_val("empty_rw_q_hold", 32'(q), 32'(1000 + 299));
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_val("empty_rw_q", 32'(q), 32'hABCD);

    // Wrap: three rounds of 500 words pass the pointer wrap
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 500; i++) cycle(1'b1, 16'($urandom_range(0, 65535)), 1'b0, 1'b0);
      for (int i = 0; i < 500; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    end

    // sclr beats a concurrent write; following read sees empty
    for (int i = 0; i < 10; i++) cycle(1'b1, 16'(16'h5000 + i), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_val("pre_sclr_q", 32'(q), 32'h5000);
    cycle(1'b1, 16'h1234, 1'b0, 1'b1);
    check_val("sclr_usedw", 32'(usedw), 32'd0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_val("sclr_rd_q_hold", 32'(q), 32'h5000);

    // Random traffic with occasional clears
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 99) < 55), 16'($urandom_range(0, 65535)),
            1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 999) < 3));
    end

    idle_inputs();
    check_val("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
